// File: rtl/traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// traffic_phase_controller
//
// Multi-phase traffic signal sequencer. Each phase runs GREEN -> YELLOW ->
// ALLRED with interval lengths counted in tick_en pulses. Phases with no
// demand are skipped. An emergency request can pre-empt the rotation and
// hold a chosen phase green.
//
// Ports:
//   clk          - clock, rising edge
//   reset_n      - asynchronous active-low reset
//   tick_en      - timebase enable; interval timers advance only when high
//   demand       - per-phase request level (NUM_PHASES bits)
//   emerg_req    - emergency pre-emption request level
//   emerg_phase  - phase to force green; values >= NUM_PHASES are ignored
//   lights       - one 3-bit group per phase: 100 red, 010 yellow, 001 green
//   phase        - current / last-served phase index
//   state        - 0 ALLRED, 1 GREEN, 2 YELLOW
//   phase_start  - one-cycle pulse in the first cycle of each GREEN
// ---------------------------------------------------------------------------
module traffic_phase_controller #(
    parameter int NUM_PHASES   = 4,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick_en,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    emerg_req,
    input  logic [2:0]              emerg_phase,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [2:0]              phase,
    output logic [1:0]              state,
    output logic                    phase_start
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [3:0]       NUM_P4      = 4'(NUM_PHASES);
    localparam logic [2:0]       LAST_PHASE  = 3'(NUM_PHASES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_phase;
    logic [2:0]       w_phase_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_hold;         // GREEN was held by an emergency last cycle
    logic             w_hold_nxt;
    logic             r_phase_start;

    logic             w_emerg_valid;
    logic             w_expire;
    logic [2:0]       w_next_phase;
    logic [3:0]       w_dist;
    logic [3:0]       w_best;

    // An out-of-range emergency phase behaves exactly like no request.
    assign w_emerg_valid = emerg_req && ({1'b0, emerg_phase} < NUM_P4);
    assign w_expire      = tick_en && (r_timer == '0);

    // Demand-driven successor: the requesting phase at the smallest cyclic
    // distance after r_phase wins; with no demand at all, plain rotation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_next_phase = (r_phase >= LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
        w_best       = 4'hF;
        w_dist       = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if ({1'b0, r_phase} < 4'(i)) begin
                w_dist = 4'(i) - {1'b0, r_phase} - 4'd1;
            end else begin
                w_dist = 4'(i) + NUM_P4 - {1'b0, r_phase} - 4'd1;
            end
            if (demand[i] && (w_dist < w_best)) begin
                w_best       = w_dist;
                w_next_phase = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_timer_nxt = r_timer;
        w_hold_nxt  = 1'b0;
        case (r_state)
            ST_ALLRED: begin
                if (w_expire) begin
                    w_state_nxt = ST_GREEN;
                    w_phase_nxt = w_emerg_valid ? emerg_phase : w_next_phase;
                    w_timer_nxt = GREEN_LOAD;
                end else if (tick_en) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            ST_GREEN: begin
                if (w_emerg_valid && (emerg_phase == r_phase)) begin
                    // Hold green; timer frozen regardless of tick_en.
                    w_hold_nxt = 1'b1;
                end else if (w_emerg_valid) begin
                    // Another phase is pre-empting: truncate green now.
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = YELLOW_LOAD;
                end else if (r_hold) begin
                    // Hold just released: grant a fresh minimum green.
                    w_timer_nxt = GREEN_LOAD;
                end else if (w_expire) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = YELLOW_LOAD;
                end else if (tick_en) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            ST_YELLOW: begin
                if (w_expire) begin
                    w_state_nxt = ST_ALLRED;
                    w_timer_nxt = ALLRED_LOAD;
                end else if (tick_en) begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ALLRED;
                w_timer_nxt = ALLRED_LOAD;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ALLRED;
            r_phase       <= LAST_PHASE;
            r_timer       <= ALLRED_LOAD;
            r_hold        <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_timer       <= w_timer_nxt;
            r_hold        <= w_hold_nxt;
            r_phase_start <= (w_state_nxt == ST_GREEN) && (r_state != ST_GREEN);
        end
    end

    // Moore lamp decode: only the current phase can be non-red.
    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            lights[3*i +: 3] = 3'b100;
            if (r_phase == 3'(i)) begin
                if (r_state == ST_GREEN) begin
                    lights[3*i +: 3] = 3'b001;
                end else if (r_state == ST_YELLOW) begin
                    lights[3*i +: 3] = 3'b010;
                end
            end
        end
    end

    assign phase       = r_phase;
    assign state       = r_state;
    assign phase_start = r_phase_start;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_controller
//
// Directed and randomized bench. A reference model tracks mode, served phase
// and remaining ticks per interval; outputs of the 4-phase instance are
// compared against it every cycle. Two extra instances (2 and 8 phases, full
// demand) are checked for lamp exclusivity and strict round-robin order.
// ---------------------------------------------------------------------------
module tb_traffic_phase_controller;

    localparam int N = 4;
    localparam int G = 4;
    localparam int Y = 2;
    localparam int R = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick_en;
    logic [3:0]  demand;
    logic        emerg_req;
    logic [2:0]  emerg_phase;
    logic [11:0] d_lights;
    logic [2:0]  d_phase;
    logic [1:0]  d_state;
    logic        d_ps;

    logic [5:0]  s2_lights;
    logic [2:0]  s2_phase;
    logic [1:0]  s2_state;
    logic        s2_ps;
    logic [23:0] s8_lights;
    logic [2:0]  s8_phase;
    logic [1:0]  s8_state;
    logic        s8_ps;

    int checks   = 0;
    int failures = 0;
    int exp2     = 0;
    int exp8     = 0;

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .NUM_PHASES(N), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(R), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .demand(demand),
        .emerg_req(emerg_req), .emerg_phase(emerg_phase),
        .lights(d_lights), .phase(d_phase), .state(d_state), .phase_start(d_ps)
    );

    traffic_phase_controller #(
        .NUM_PHASES(2), .GREEN_TICKS(2), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .CNT_W(4)
    ) dut_s2 (
        .clk(clk), .reset_n(reset_n), .tick_en(1'b1), .demand(2'b11),
        .emerg_req(1'b0), .emerg_phase(3'd0),
        .lights(s2_lights), .phase(s2_phase), .state(s2_state), .phase_start(s2_ps)
    );

    traffic_phase_controller #(
        .NUM_PHASES(8), .GREEN_TICKS(2), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .CNT_W(4)
    ) dut_s8 (
        .clk(clk), .reset_n(reset_n), .tick_en(1'b1), .demand(8'hFF),
        .emerg_req(1'b0), .emerg_phase(3'd0),
        .lights(s8_lights), .phase(s8_phase), .state(s8_state), .phase_start(s8_ps)
    );

    // ---------------- reference model ----------------
    // st: 0 all-red, 1 green, 2 yellow; rem: ticks still to run in interval.
    typedef struct {
        int st;
        int ph;
        int rem;
        bit hold;
        bit ps;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.ph = N - 1; r.rem = R; r.hold = 1'b0; r.ps = 1'b0;
        return r;
    endfunction

    function automatic int pick_next(int ph, logic [3:0] dem, bit ev, int ep);
        int idx;
        if (ev) return ep;
        for (int k = 1; k <= N; k++) begin
            idx = (ph + k) % N;
            if (dem[idx[1:0]]) return idx;
        end
        return (ph + 1) % N;
    endfunction

    function automatic mdl_t mdl_step(mdl_t cur, bit tk, logic [3:0] dem, bit er, int ep);
        mdl_t n;
        bit   ev;
        n    = cur;
        ev   = er && (ep < N);
        n.ps = 1'b0;
        case (cur.st)
            0: if (tk) begin
                n.rem = cur.rem - 1;
                if (n.rem == 0) begin
                    n.st = 1; n.ph = pick_next(cur.ph, dem, ev, ep); n.rem = G; n.ps = 1'b1;
                end
            end
            1: begin
                if (ev && ep == cur.ph) begin
                    n.hold = 1'b1;
                end else if (ev) begin
                    n.st = 2; n.rem = Y; n.hold = 1'b0;
                end else if (cur.hold) begin
                    n.rem = G; n.hold = 1'b0;
                end else if (tk) begin
                    n.rem = cur.rem - 1;
                    if (n.rem == 0) begin n.st = 2; n.rem = Y; end
                end
            end
            default: if (tk) begin
                n.rem = cur.rem - 1;
                if (n.rem == 0) begin n.st = 0; n.rem = R; end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= mdl_reset();
        else          m <= mdl_step(m, tick_en, demand, emerg_req, int'(emerg_phase));
    end

    function automatic logic [11:0] exp_lights(int st, int ph);
        logic [11:0] l;
        logic [2:0]  g;
        l = '0;
        for (int i = 0; i < N; i++) begin
            g = 3'b100;
            if (i == ph && st == 1) g = 3'b001;
            if (i == ph && st == 2) g = 3'b010;
            l = l | (12'(g) << (3 * i));
        end
        return l;
    endfunction

    // 1 when every group is a legal one-hot code and at most one is non-red.
    function automatic logic [31:0] lights_ok(logic [23:0] l, int n);
        int         nonred;
        int         bad;
        logic [2:0] g;
        nonred = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            g = 3'(l >> (3 * i));
            if (g != 3'b100) nonred++;
            if (g != 3'b100 && g != 3'b010 && g != 3'b001) bad++;
        end
        return (bad == 0 && nonred <= 1) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("model_state",  32'(d_state),  m.st);
        check("model_phase",  32'(d_phase),  m.ph);
        check("model_lights", 32'(d_lights), 32'(exp_lights(m.st, m.ph)));
        check("model_pstart", 32'(d_ps),     32'(m.ps));
        check("main_exclusive", lights_ok({12'd0, d_lights}, N), 32'd1);
    endtask

    task automatic sweep_check();
        check("sweep2_exclusive", lights_ok({18'd0, s2_lights}, 2), 32'd1);
        check("sweep8_exclusive", lights_ok(s8_lights, 8), 32'd1);
        if (s2_ps) begin
            check("sweep2_order", 32'(s2_phase), exp2);
            exp2 = (exp2 + 1) % 2;
        end
        if (s8_ps) begin
            check("sweep8_order", 32'(s8_phase), exp8);
            exp8 = (exp8 + 1) % 8;
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
        check_model();
        sweep_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  exp_ph;
        int  p;
        int  glen;
        int  frozen_ph;
        bit  counting;
        bit  done;
        bit  found;

        reset_n = 1'b0; tick_en = 1'b1; demand = 4'hF;
        emerg_req = 1'b0; emerg_phase = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_lights", 32'(d_lights), 32'h924);
        check("reset_state",  32'(d_state),  32'd0);
        check("reset_phase",  32'(d_phase),  32'd3);
        check("reset_pstart", 32'(d_ps),     32'd0);

        // Full demand, tick every clk: 7-cycle period per phase.
        reset_n = 1'b1;
        exp2 = 0; exp8 = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 0) begin
                check_model();
                sweep_check();
            end else begin
                next_cycle();
            end
            if (c == 0) begin
                check("seq_state", 32'(d_state), 32'd0);
                check("seq_phase", 32'(d_phase), 32'd3);
            end else begin
                p = (c - 1) % 7;
                check("seq_state", 32'(d_state), (p < 4) ? 32'd1 : (p < 6) ? 32'd2 : 32'd0);
                check("seq_phase", 32'(d_phase), 32'(((c - 1) / 7) % 4));
                check("seq_pstart", 32'(d_ps), (p == 0) ? 32'd1 : 32'd0);
            end
        end

        // Demand on phases 0 and 2 only: they alternate, 1 and 3 stay red.
        demand = 4'b0101;
        exp_ph = (m.ph == 2 || m.ph == 3) ? 0 : 2;
        for (int c = 0; c < 56; c++) begin
            next_cycle();
            check("alt_grp1_red", 32'(d_lights[5:3]),  32'(3'b100));
            check("alt_grp3_red", 32'(d_lights[11:9]), 32'(3'b100));
            if (d_ps) begin
                check("alt_phase", 32'(d_phase), exp_ph);
                exp_ph = 2 - exp_ph;
            end
        end

        // No demand: plain rotation.
        demand = 4'b0000;
        exp_ph = (m.ph + 1) % N;
        for (int c = 0; c < 56; c++) begin
            next_cycle();
            if (d_ps) begin
                check("rot_phase", 32'(d_phase), exp_ph);
                exp_ph = (exp_ph + 1) % N;
            end
        end

        // Slow timebase (one tick per 4 clks): green spans 16 clks.
        demand = 4'hF;
        glen = 0; counting = 1'b0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick_en = (k % 4 == 0);
            next_cycle();
            if (d_ps) begin
                counting = 1'b1;
                glen = 0;
            end
            if (counting) begin
                if (d_state == 2'd1) glen++;
                else done = 1'b1;
            end
        end
        check("slow_green_done", 32'(done), 32'd1);
        check("slow_green_len",  glen,      32'd16);

        // Timebase stalled mid-yellow: everything frozen.
        tick_en = 1'b0;
        frozen_ph = m.ph;
        for (int c = 0; c < 50; c++) begin
            next_cycle();
            check("freeze_state",  32'(d_state),  32'd2);
            check("freeze_lights", 32'(d_lights), 32'(exp_lights(2, frozen_ph)));
        end
        tick_en = 1'b1;

        // Asynchronous reset in the middle of phase 3 green.
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            next_cycle();
            if (d_state == 2'd1 && d_phase == 3'd3) found = 1'b1;
        end
        check("wait_phase3_green", 32'(found), 32'd1);
        next_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_lights", 32'(d_lights), 32'h924);
        check("async_rst_state",  32'(d_state),  32'd0);
        check("async_rst_phase",  32'(d_phase),  32'd3);
        exp2 = 0; exp8 = 0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        check_model();
        check("rel_c0_state", 32'(d_state), 32'd0);
        next_cycle();
        check("rel_c1_state", 32'(d_state), 32'd1);
        check("rel_c1_phase", 32'(d_phase), 32'd0);
        check("rel_c1_pstart", 32'(d_ps),   32'd1);

        // Emergency for phase 2 arriving in phase 0 green (cycle 2).
        next_cycle();
        emerg_req = 1'b1; emerg_phase = 3'd2;
        next_cycle();
        check("emg_c3_yellow", 32'(d_state), 32'd2);
        next_cycle();
        check("emg_c4_yellow", 32'(d_state), 32'd2);
        next_cycle();
        check("emg_c5_allred", 32'(d_state), 32'd0);
        next_cycle();
        check("emg_c6_green", 32'(d_state), 32'd1);
        check("emg_c6_phase", 32'(d_phase), 32'd2);
        check("emg_c6_pstart", 32'(d_ps),   32'd1);
        for (int c = 0; c < 30; c++) begin
            tick_en = 1'($urandom_range(0, 1));
            next_cycle();
            check("emg_hold_state", 32'(d_state), 32'd1);
            check("emg_hold_phase", 32'(d_phase), 32'd2);
            check("emg_hold_pstart", 32'(d_ps),   32'd0);
        end
        tick_en = 1'b1;
        emerg_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            check("emg_min_green", 32'(d_state), 32'd1);
        end
        next_cycle();
        check("emg_min_green_end", 32'(d_state), 32'd2);

        // Out-of-range emergency phase is ignored.
        emerg_req = 1'b1; emerg_phase = 3'd5;
        for (int c = 0; c < 40; c++) next_cycle();
        emerg_req = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            tick_en = ($urandom_range(0, 3) != 0);
            demand  = 4'($urandom);
            if ($urandom_range(0, 24) == 0) emerg_req = ~emerg_req;
            if ($urandom_range(0, 29) == 0) emerg_phase = 3'($urandom_range(0, 7));
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised multi-approach traffic signal sequencer that generalises the team's fixed four-light, four-state controller. It supports NUM_PHASES signal phases with counted green, yellow and all-red clearance intervals, and skips phases that have no demand. It also provides an emergency pre-emption hold. The block sits between a timebase divider, which supplies `tick_en`, and the lamp driver, which consumes the one-hot `lights` vector.

## Interface
- NUM_PHASES, 4, number of phases, 2..8; one 3-bit light group per phase
- GREEN_TICKS, 8, green duration in `tick_en` pulses, ≥1
- YELLOW_TICKS, 3, yellow duration in `tick_en` pulses, ≥1
- ALLRED_TICKS, 1, all-red clearance duration in `tick_en` pulses, ≥1
- CNT_W, 8, timer width; each *_TICKS must be ≤ 2^CNT_W

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick_en  in  1  timebase enable; timers advance only when high
- demand  in  NUM_PHASES  per-phase request, level, sampled every clk
- emerg_req  in  1  emergency pre-emption request, level
- emerg_phase  in  3  phase to force green; ≥NUM_PHASES means no request
- lights  out  3*NUM_PHASES  group i = bits [3i+2:3i]; 100 red, 010 yellow, 001 green
- phase  out  3  current/last-served phase index
- state  out  2  0 ALLRED, 1 GREEN, 2 YELLOW
- phase_start  out  1  one-cycle registered pulse in first cycle of each GREEN

## Operation
- Registered FSM (`state`, `phase`, `timer`). `lights` is decoded from state and phase (Moore). Only `phase` may show green or yellow; every other group shows red. ALLRED drives all groups red. Encoding 3 is unreachable; it decodes all red and returns to ALLRED next clk.
- Interval entry loads `timer` = TICKS-1. Each `tick_en` decrements it. `expire` = `tick_en` && `timer`==0; the transition happens on that edge.
- ALLRED expire → GREEN of next phase:
  - If a valid emergency is active (emerg_req=1 and emerg_phase<NUM_PHASES), next phase = emerg_phase.
  - Otherwise, next phase = first index after `phase`, searching cyclically (phase+1 … phase), with `demand` bit set.
  - If `demand`==0, next phase = (phase+1) mod NUM_PHASES.
- GREEN expire → YELLOW. YELLOW expire → ALLRED.
- Emergency in GREEN, phase==emerg_phase: timer frozen, stays GREEN regardless of `tick_en`. On release (or emerg_phase change), timer reloads GREEN_TICKS-1 (minimum green).
- Emergency in GREEN, phase≠emerg_phase: goes to YELLOW at next clk (green truncated).
- Emergency in YELLOW or ALLRED: the interval completes normally; clearance is never shortened.
- Invalid emerg_phase is treated as emerg_req=0.
- Demand and emergency inputs are sampled only at decision points; there is no latching.

## Timing
- Reset (async assert, any state):
  - state=ALLRED, phase=NUM_PHASES-1, timer=ALLRED_TICKS-1.
  - lights all 100, phase_start=0.
  - First green after release is phase 0 when demand[0]=1 or demand==0.
- With `tick_en` held high, each interval lasts exactly TICKS clk cycles.
- With `tick_en` low, state and timer hold, except for emergency truncation (GREEN→YELLOW), which does not need `tick_en`.
- phase_start is high in the same cycle state first reads GREEN; it pulses again after an emergency-hold release only if GREEN is re-entered.
- Output latency: lights change in the same cycle as state (zero cycles after the registering edge).
- Single-phase demand (e.g. demand=0001) re-serves that phase every cycle. The ALLRED and YELLOW intervals are still inserted between consecutive greens.

## Test plan
- NUM_PHASES=4, G=4, Y=2, R=1, tick_en=1, demand=F, release reset at cycle 0 -> ALLRED cycle 0; phase0 GREEN cycles 1-4 (phase_start at 1); YELLOW 5-6; ALLRED 7; phase1 GREEN 8-11; period 7 cycles per phase, phases 0,1,2,3,0 in order.
- demand=0101 -> greens alternate phase 0, 2, 0, 2; groups 1 and 3 constant 100; demand=0 -> plain cycle 0,1,2,3.
- tick_en=1 every 4th clk, G=4 -> GREEN lasts 16 clks; tick_en=0 for 50 clks mid-YELLOW -> state and lights frozen.
- emerg_req=1, emerg_phase=2 during phase0 GREEN cycle 2 -> YELLOW at cycle 3, ALLRED, then phase2 GREEN held indefinitely. Release -> exactly 4 more GREEN cycles, then YELLOW. emerg_phase=5 -> no effect.
- reset_n low mid-GREEN of phase 3 -> lights all 100 asynchronously, state=0, phase=3; release -> ALLRED 1 cycle, then phase0 GREEN.
- Sweep NUM_PHASES=2 and 8 with demand all-ones -> each phase green exactly once per round and never two groups non-red at once (assertion checked every clk).
